// File: rtl/tile_scroll_renderer_if.sv
// tile_scroll_renderer_if
// Memory-side bus of the background renderer: the registered image ROM
// address, the returned palette index, and the combinational palette colour.
//   rom_address  renderer -> ROM   registered texel address
//   rom_q        ROM -> renderer   palette index, one cycle after rom_address
//   pal_index    renderer -> pal   palette lookup index (equals rom_q)
//   pal_red/green/blue  pal -> renderer  colour for pal_index
// master: renderer side; slave: ROM/palette side.
interface tile_scroll_renderer_if #(
  parameter int IDX_W  = 8,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_index;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;

  modport master (
    output rom_address, pal_index,
    input  rom_q, pal_red, pal_green, pal_blue
  );

  modport slave (
    input  rom_address, pal_index,
    output rom_q, pal_red, pal_green, pal_blue
  );
endinterface

// File: rtl/tile_scroll_renderer.sv
// tile_scroll_renderer
// Maps the VGA raster onto an IMG_W x IMG_H indexed background image with
// integer pixel replication (SCALE_X x SCALE_Y) and frame-synchronous
// wrap-around scrolling. Texel coordinates come from replication counters
// that follow DrawX/DrawY changes, so no divider sits on the raster path.
// Ports:
//   vga_clk, Reset       pixel clock, async active-high reset
//   DrawX, DrawY, blank  raster position and active-video flag (1 = active)
//   scroll_x/y, scroll_we  scroll request; captured into pending registers
//   mem                  ROM/palette bus (master side)
//   red/green/blue       registered pixel colour, 0 outside active video
//   transparent          registered: pixel index == TRANSP_IDX and active
//   scroll_err           one-cycle pulse: request rejected (field out of range)
// Latency: position at t -> rom_address at t+1 -> rom_q/palette at t+2 ->
// red/green/blue/transparent at t+3.
module tile_scroll_renderer #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int SCALE_X    = 20,
  parameter int SCALE_Y    = 15,
  parameter int IDX_W      = 8,
  parameter int ADDR_W     = 10,
  parameter int TRANSP_IDX = 0
) (
  input  logic                   vga_clk,
  input  logic                   Reset,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   blank,
  input  logic [9:0]             scroll_x,
  input  logic [9:0]             scroll_y,
  input  logic                   scroll_we,
  tile_scroll_renderer_if.master mem,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   transparent,
  output logic                   scroll_err
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  // +1 keeps the counters at least one bit wide when SCALE_* == 1
  localparam int SX_W   = $clog2(SCALE_X + 1);
  localparam int SY_W   = $clog2(SCALE_Y + 1);
  // blank delay registers ahead of the output register
  localparam int STAGES = 2;

  typedef struct packed {
    logic [ROW_W-1:0] y;
    logic [COL_W-1:0] x;
  } scroll_t;

  scroll_t          pend, act, act_eff;
  logic [9:0]       prev_x, prev_y;
  logic             prev_vld;
  logic             frame_start, req_ok;

  logic [SX_W-1:0]  sub_x, sub_x_n;
  logic [SY_W-1:0]  sub_y, sub_y_n;
  logic [COL_W-1:0] col, col_n;
  logic [ROW_W-1:0] row, row_n;
  logic [ADDR_W-1:0] addr_n;

  logic [STAGES:1]  vld_pipe;

  // Frame start fires once per arrival at the origin, so a raster stalled
  // on (0,0) does not re-trigger it. prev_vld makes the very first origin
  // after reset count even though prev_x/prev_y reset to 0.
  assign frame_start = (DrawX == '0) && (DrawY == '0) &&
                       !(prev_vld && (prev_x == '0) && (prev_y == '0));

  // The origin pixel of a frame already uses the scroll being promoted.
  assign act_eff = frame_start ? pend : act;

  assign req_ok = (32'(scroll_x) < IMG_W) && (32'(scroll_y) < IMG_H);

  // Horizontal replication: reload at column 0, step on each DrawX change.
  always_comb begin
    sub_x_n = sub_x;
    col_n   = col;
    if (DrawX == '0) begin
      sub_x_n = '0;
      col_n   = act_eff.x;
    end else if (DrawX != prev_x) begin
      if (sub_x == SX_W'(SCALE_X - 1)) begin
        sub_x_n = '0;
        col_n   = (col == COL_W'(IMG_W - 1)) ? '0 : col + 1'b1;
      end else begin
        sub_x_n = sub_x + 1'b1;
      end
    end
  end

  // Vertical replication: same scheme keyed on DrawY.
  always_comb begin
    sub_y_n = sub_y;
    row_n   = row;
    if (DrawY == '0) begin
      sub_y_n = '0;
      row_n   = act_eff.y;
    end else if (DrawY != prev_y) begin
      if (sub_y == SY_W'(SCALE_Y - 1)) begin
        sub_y_n = '0;
        row_n   = (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
      end else begin
        sub_y_n = sub_y + 1'b1;
      end
    end
  end

  // IMG_W is a constant, so this is a constant multiply, not a datapath one.
  assign addr_n = ADDR_W'(row_n) * ADDR_W'(IMG_W) + ADDR_W'(col_n);

  assign mem.pal_index = mem.rom_q;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      prev_x          <= '0;
      prev_y          <= '0;
      prev_vld        <= 1'b0;
      sub_x           <= '0;
      sub_y           <= '0;
      col             <= '0;
      row             <= '0;
      pend            <= '0;
      act             <= '0;
      scroll_err      <= 1'b0;
      mem.rom_address <= '0;
      vld_pipe        <= '0;
      red             <= '0;
      green           <= '0;
      blue            <= '0;
      transparent     <= 1'b0;
    end else begin
      prev_x          <= DrawX;
      prev_y          <= DrawY;
      prev_vld        <= 1'b1;
      sub_x           <= sub_x_n;
      sub_y           <= sub_y_n;
      col             <= col_n;
      row             <= row_n;
      mem.rom_address <= addr_n;

      // Promotion reads pend before this cycle's write lands, so a request
      // on the frame-start cycle waits for the following frame.
      if (frame_start)
        act <= pend;
      if (scroll_we && req_ok) begin
        pend.x <= COL_W'(scroll_x);
        pend.y <= ROW_W'(scroll_y);
      end
      scroll_err <= scroll_we && !req_ok;

      vld_pipe <= {vld_pipe[STAGES-1:1], blank};

      if (vld_pipe[STAGES]) begin
        red         <= mem.pal_red;
        green       <= mem.pal_green;
        blue        <= mem.pal_blue;
        transparent <= (mem.rom_q == IDX_W'(TRANSP_IDX));
      end else begin
        red         <= '0;
        green       <= '0;
        blue        <= '0;
        transparent <= 1'b0;
      end
    end
  end

endmodule
